// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port memory sequencer for a multicycle CPU.
// Takes MemRd/MemWr from the controller, drives one bus access and lands read
// data in IR or MDR. Optional build macro MEM_TIMEOUT_EN adds an ack watchdog
// that aborts an access after TIMEOUT cycles without bus_ack.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        iord,
   input  logic        ir_wr,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] wr_data,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_req,
   output logic        bus_we,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic [31:0] ir,
   output logic [31:0] mdr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ACCESS, FIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic        we_q, we_d;
   logic        dst_ir_q, dst_ir_d;
   logic        err_q, err_d;
   logic [31:0] sel_addr;

`ifdef MEM_TIMEOUT_EN
   // Wide enough to hold TIMEOUT; compared as 32 bits against the parameter.
   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   assign sel_addr = iord ? alu_out : pc;

   // Next-state, address/data latch, read-data steering and error capture.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      we_d     = we_q;
      dst_ir_d = dst_ir_q;
      err_d    = err_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_rd && mem_wr) begin
               // Conflicting request: flag it, start nothing.
               err_d = 1'b1;
            end else if (mem_rd || mem_wr) begin
               if (sel_addr[1:0] != 2'b00) begin
                  err_d = 1'b1;
               end else begin
                  addr_d   = sel_addr;
                  wdata_d  = wr_data;
                  we_d     = mem_wr;
                  dst_ir_d = ir_wr;
`ifdef MEM_TIMEOUT_EN
                  cnt_d    = '0;
`endif
                  state_d  = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (bus_ack) begin
               if (!we_q) begin
                  if (dst_ir_q) ir_d  = bus_rdata;
                  else          mdr_d = bus_rdata;
               end
               state_d = FIN;
`ifdef MEM_TIMEOUT_EN
            end else if (32'(cnt_q) >= TIMEOUT - 32'd1) begin
               // Memory never answered: abort without touching IR/MDR.
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         ir_q     <= '0;
         mdr_q    <= '0;
         we_q     <= 1'b0;
         dst_ir_q <= 1'b0;
         err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ir_q     <= ir_d;
         mdr_q    <= mdr_d;
         we_q     <= we_d;
         dst_ir_q <= dst_ir_d;
         err_q    <= err_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Bus handshake and status are pure decodes of the state register, so
   // reset drops them at the same edge and IDLE/FIN never strobe the bus.
   assign bus_req   = (state_q == ACCESS);
   assign busy      = (state_q == ACCESS);
   assign bus_we    = (state_q == ACCESS) && we_q;
   assign done      = (state_q == FIN);
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign ir        = ir_q;
   assign mdr       = mdr_q;
   assign err       = err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for bus_ack before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port mem_rd  input  1  read request from controller (MemRd).
REQ-005 SHALL have port mem_wr  input  1  write request from controller (MemWr).
REQ-006 SHALL have port iord  input  1  address select: 0 = pc, 1 = alu_out.
REQ-007 SHALL have port ir_wr  input  1  read destination: 1 = ir, 0 = mdr.
REQ-008 SHALL have ports pc, alu_out, wr_data  input  32 each  PC, ALU result register, store data (register B).
REQ-009 SHALL have ports bus_addr, bus_wdata  output  32 each  memory address and write data.
REQ-010 SHALL have ports bus_req, bus_we  output  1 each  access request and write strobe.
REQ-011 SHALL have ports bus_rdata  input  32, and bus_ack  input  1  read data and access complete.
REQ-012 SHALL have ports ir, mdr  output  32 each  instruction register and memory data register.
REQ-013 SHALL have ports busy, done, err  output  1 each  access in flight, one-cycle completion pulse, sticky error.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, FIN.
REQ-015 IDLE: at an edge with exactly one of mem_rd/mem_wr high and a word-aligned selected address, SHALL latch bus_addr (pc if iord=0, else alu_out), bus_wdata = wr_data, bus_we = mem_wr, the ir_wr destination, and go to ACCESS.
REQ-016 ACCESS: bus_req SHALL be 1 and busy SHALL be 1; bus_addr, bus_wdata and bus_we SHALL be held stable.
REQ-017 ACCESS with bus_ack=1 at an edge: a read SHALL load bus_rdata into ir (latched ir_wr=1) or mdr (ir_wr=0); a write SHALL change neither; next state FIN.
REQ-018 FIN SHALL last one cycle, with done=1, bus_req=0, busy=0, and then return to IDLE; a new request is accepted only in IDLE (FIN and ACCESS ignore mem_rd/mem_wr).
REQ-019 Zero-wait memory (ack in first ACCESS cycle): request edge to done high SHALL be 2 cycles; each wait cycle adds 1.
REQ-020 mem_rd and mem_wr both high in IDLE SHALL start no access, SHALL set err, and SHALL stay in IDLE.
REQ-021 Selected address with bits [1:0] != 0 in IDLE SHALL start no access, SHALL set err, and SHALL stay in IDLE.
REQ-022 bus_ack outside ACCESS SHALL be ignored.
REQ-023 In IDLE and FIN, bus_req and bus_we SHALL be 0.
REQ-024 err SHALL be sticky until reset.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE and clear ir, mdr, bus_addr, bus_wdata, bus_req, bus_we, busy, done, err and the timeout counter to 0.
REQ-026 Reset during ACCESS SHALL drop bus_req at that edge, load no data and produce no done pulse.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN defined: a counter SHALL count ACCESS cycles without ack; at TIMEOUT cycles it SHALL abort to FIN with err=1, ir/mdr unchanged, and done pulsed.
REQ-028 Macro MEM_TIMEOUT_EN undefined: there SHALL be no counter, ACCESS SHALL wait indefinitely, and err SHALL come only from REQ-020/021.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Fetch: pc=0x00000040, mem_rd=1, iord=0, ir_wr=1, ack in first ACCESS cycle with rdata=0x8C220004 -> bus_addr=0x40, ir=0x8C220004 and done 2 cycles after request, mdr=0.
- Load with 3 wait cycles: alu_out=0x100, iord=1, ir_wr=0, rdata=0xDEADBEEF -> mdr=0xDEADBEEF, done 5 cycles after request, ir unchanged.
- Store: mem_wr=1, alu_out=0x200, wr_data=0x12345678 -> bus_we=1, bus_wdata=0x12345678 held through ACCESS, ir/mdr unchanged, done pulse.
- Illegal requests: mem_rd=mem_wr=1 -> err=1, bus_req stays 0; separately, after reset, alu_out=0x102 with iord=1 -> err=1, no access.
- Reset mid-access: rst_n=0 during ACCESS -> bus_req=0 next cycle, no done, ir=mdr=0.
- MEM_TIMEOUT_EN with TIMEOUT=4 and no ack -> bus_req high exactly 4 cycles, then done=1, err=1.
